inst_dec: RTL and testbench

Instruction decode stage of the 16-bit RISC core. It takes the fetched 16-bit instruction word and splits it into the following:
- ALU operation code
- register-file read selects (A, B) and write select (D)
- a 16-bit immediate
- a register write-enable

All outputs are registered and gated by a stage enable from the pipeline controller. Outputs feed the register file and the ALU stage.

---
 rtl/inst_dec_pkg.sv | 38 +++
 rtl/inst_dec.sv | 63 ++++++
 tb/tb_inst_dec.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_dec_pkg.sv
// Shared decode constants for the 16-bit RISC core: opcode map, instruction field
// positions and the register-write qualifier also used by hazard logic.
package inst_dec_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_LOADI = 4'h9;
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_CMP   = 4'hC;
  localparam logic [3:0] OP_JUMP  = 4'hD;
  localparam logic [3:0] OP_BEQ   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned D_HI   = 11;
  localparam int unsigned D_LO   = 8;
  localparam int unsigned A_HI   = 7;
  localparam int unsigned A_LO   = 4;
  localparam int unsigned B_HI   = 3;
  localparam int unsigned B_LO   = 0;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  // ALU ops and both loads write a destination register; the rest do not.
  function automatic logic regwe_of(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_LOAD);
  endfunction

endpackage

// File: rtl/inst_dec.sv
// Instruction decode stage: splits the fetched word into ALU op, register selects,
// sign-extended immediate and register write enable, all registered behind I_en.
module inst_dec
  import inst_dec_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_SEL_W = 4
) (
  input  logic                 I_clk,
  input  logic                 I_rstn,
  input  logic                 I_en,
  input  logic [DATA_W-1:0]    I_inst,
  output logic [3:0]           O_aluop,
  output logic [REG_SEL_W-1:0] O_selA,
  output logic [REG_SEL_W-1:0] O_selB,
  output logic [REG_SEL_W-1:0] O_selD,
  output logic [DATA_W-1:0]    O_imm,
  output logic                 O_regwe
);

  logic [3:0]           aluop_d, aluop_q;
  logic [REG_SEL_W-1:0] sela_d, sela_q;
  logic [REG_SEL_W-1:0] selb_d, selb_q;
  logic [REG_SEL_W-1:0] seld_d, seld_q;
  logic [DATA_W-1:0]    imm_d, imm_q;
  logic                 regwe_d, regwe_q;

  // Fields are extracted regardless of opcode; later stages ignore what they don't need.
  always_comb begin
    aluop_d = I_inst[OPC_HI:OPC_LO];
    seld_d  = I_inst[D_HI:D_LO];
    sela_d  = I_inst[A_HI:A_LO];
    selb_d  = I_inst[B_HI:B_LO];
    imm_d   = {{(DATA_W - 8){I_inst[IMM_HI]}}, I_inst[IMM_HI:IMM_LO]};
    regwe_d = regwe_of(aluop_d);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      aluop_q <= '0;
      sela_q  <= '0;
      selb_q  <= '0;
      seld_q  <= '0;
      imm_q   <= '0;
      regwe_q <= 1'b0;
    end else if (I_en) begin
      aluop_q <= aluop_d;
      sela_q  <= sela_d;
      selb_q  <= selb_d;
      seld_q  <= seld_d;
      imm_q   <= imm_d;
      regwe_q <= regwe_d;
    end
  end

  assign O_aluop = aluop_q;
  assign O_selA  = sela_q;
  assign O_selB  = selb_q;
  assign O_selD  = seld_q;
  assign O_imm   = imm_q;
  assign O_regwe = regwe_q;

endmodule

// File: tb/tb_inst_dec.sv
// Self-checking bench for inst_dec: directed plan plus random traffic against an
// arithmetic reference model of the decode rules.
module tb_inst_dec;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] inst;
  logic [3:0]  aluop, sela, selb, seld;
  logic [15:0] imm;
  logic        regwe;

  int errors = 0;
  int checks = 0;

  // Reference model state (what the outputs should show after the last edge).
  int m_aluop, m_sela, m_selb, m_seld, m_imm, m_regwe;

  inst_dec #(
    .DATA_W   (16),
    .REG_SEL_W(4)
  ) dut (
    .I_clk  (clk),
    .I_rstn (rstn),
    .I_en   (en),
    .I_inst (inst),
    .O_aluop(aluop),
    .O_selA (sela),
    .O_selB (selb),
    .O_selD (seld),
    .O_imm  (imm),
    .O_regwe(regwe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model one rising edge using the inputs currently applied.
  task automatic model_edge();
    int w, op, v;
    w = int'(inst);
    if (rstn === 1'b0) begin
      m_aluop = 0; m_sela = 0; m_selb = 0; m_seld = 0; m_imm = 0; m_regwe = 0;
    end else if (en === 1'b1) begin
      op      = w / 4096;
      m_aluop = op;
      m_seld  = (w / 256) % 16;
      m_sela  = (w / 16) % 16;
      m_selb  = w % 16;
      v       = w % 256;
      if (v >= 128) v = v - 256;
      m_imm   = (v + 65536) % 65536;
      m_regwe = (op >= 1 && op <= 10) ? 1 : 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".aluop"}, {12'h0, aluop}, 16'(m_aluop));
    check({tag, ".selA"},  {12'h0, sela},  16'(m_sela));
    check({tag, ".selB"},  {12'h0, selb},  16'(m_selb));
    check({tag, ".selD"},  {12'h0, seld},  16'(m_seld));
    check({tag, ".imm"},   imm,            16'(m_imm));
    check({tag, ".regwe"}, {15'h0, regwe}, 16'(m_regwe));
  endtask

  initial begin
    m_aluop = 0; m_sela = 0; m_selb = 0; m_seld = 0; m_imm = 0; m_regwe = 0;
    rstn = 1'b0; en = 1'b1; inst = 16'h1704;
    #2;
    step();
    step();
    check_all("reset");
    check("reset.all_zero", {aluop, sela, selb, regwe, 3'b0}, 16'h0000);

    rstn = 1'b1; en = 1'b0;
    step();
    step();
    check_all("en_low_after_reset");

    en = 1'b1;
    step();
    check_all("add_1704");
    check("add_1704.imm_const", imm, 16'h0004);
    check("add_1704.regwe_const", {15'h0, regwe}, 16'h0001);

    inst = 16'h9F80;
    step();
    check_all("loadi_9f80");
    check("loadi_9f80.imm_const", imm, 16'hFF80);

    inst = 16'hB123;
    step();
    check_all("store_b123");
    en = 1'b0; inst = 16'h2345;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("store_hold");
    end
    check("store_hold.aluop_const", {12'h0, aluop}, 16'h000B);

    en = 1'b1;
    for (int op = 0; op < 16; op++) begin
      inst = {op[3:0], 12'hA5C};
      step();
      check_all("sweep");
      check("sweep.regwe_rule", {15'h0, regwe}, (op >= 1 && op <= 10) ? 16'h0001 : 16'h0000);
    end
    rstn = 1'b0;
    step();
    check_all("midstream_reset");
    check("midstream_reset.imm_const", imm, 16'h0000);
    rstn = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 19) != 0);
      en   = ($urandom_range(0, 9) < 7);
      inst = 16'($urandom);
      step();
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
